// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-ROM address and queues {pc, inst} pairs for decode.
// Define IF_PERF_CNT_EN to add the fetch_cnt_o / flush_cnt_o performance counters.
module if_fetch_unit #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FQ_DEPTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [31:0]           pc_o,
  output logic                  misalign_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]           pc_q, pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  misalign_q, misalign_d;
  logic [31:0]           pc_mem_q   [FQ_DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem_q [FQ_DEPTH];

  logic full;
  logic deq;
  logic enq;

  assign imem_addr_o  = pc_q[ADDR_WIDTH-1:0];
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_mem_q[rd_ptr_q];
  assign pc_o         = pc_mem_q[rd_ptr_q];
  assign misalign_o   = misalign_q;

  assign full = (count_q == CNT_W'(FQ_DEPTH));
  assign deq  = inst_valid_o & inst_ready_i;
  // A full queue can still accept the fetched word when the head leaves in the same cycle.
  assign enq  = ~redirect_i & (~full | deq);

  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    if (redirect_i) begin
      pc_d     = {redirect_pc_i[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (enq) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // A head consumed during the redirect cycle reached decode, so it is not counted as flushed.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, deq};
    flush_cnt_d = flush_cnt_q;
    if (redirect_i) begin
      flush_cnt_d = flush_cnt_q + 32'(count_q) - {31'd0, deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed fetch, stall, redirect, misalign, wrap and reset scenarios.
// Counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } expEntry_t;

  logic        clk_i;
  logic        rst_ni;
  logic [12:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        misalign_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int nCompared;
  int nMismatched;
  expEntry_t expQ[$];

  if_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .misalign_o    (misalign_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  // ROM contents: word k holds 0xC0DE_0000 | k.
  function automatic logic [31:0] romWord(input logic [12:0] a);
    return 32'hC0DE_0000 | {21'd0, a[12:2]};
  endfunction

  assign imem_rdata_i = romWord(imem_addr_o);

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] redirPc,
                               input logic ready);
    rst_ni        = rst;
    redirect_i    = redir;
    redirect_pc_i = redirPc;
    inst_ready_i  = ready;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [31:0] inst);
    expQ.push_back('{pc: pc, inst: inst});
  endtask

  task automatic acceptOne();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: every handshake the next edge will complete must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && inst_valid_o === 1'b1 && inst_ready_i === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_handshake: got pc %h, want no handshake", pc_o);
      end else begin
        expEntry_t e;
        e = expQ.pop_front();
        checkOutput("hs_pc", pc_o, e.pc);
        checkOutput("hs_inst", inst_o, e.inst);
      end
    end
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    waitCycles(2);
    checkOutput("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    checkOutput("rst_pc", pc_o, 32'h0);
    checkOutput("rst_inst", inst_o, 32'h0);
    checkOutput("rst_addr", {19'd0, imem_addr_o}, 32'h0);
    checkOutput("rst_misalign", {31'd0, misalign_o}, 32'd0);

    // Streaming with decode always ready
    pushExp(32'h0, 32'hC0DE_0000);
    pushExp(32'h4, 32'hC0DE_0001);
    pushExp(32'h8, 32'hC0DE_0002);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    waitCycles(4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("stream_head_pc", pc_o, 32'hC);
    checkOutput("stream_drain", 32'(expQ.size()), 32'd0);
    waitCycles(3);
    checkOutput("full_addr_hold", {19'd0, imem_addr_o}, 32'h14);
    checkOutput("full_head_hold", pc_o, 32'hC);

    // Reset mid-stream with a full queue
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    waitCycles(1);
    checkOutput("midrst_valid", {31'd0, inst_valid_o}, 32'd0);
    checkOutput("midrst_pc", pc_o, 32'h0);
    checkOutput("midrst_addr", {19'd0, imem_addr_o}, 32'h0);

    // Backpressure from reset: queue fills, PC holds at 0x8
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    waitCycles(5);
    checkOutput("bp_addr", {19'd0, imem_addr_o}, 32'h8);
    checkOutput("bp_valid", {31'd0, inst_valid_o}, 32'd1);
    checkOutput("bp_pc", pc_o, 32'h0);
    checkOutput("bp_inst", inst_o, 32'hC0DE_0000);
    pushExp(32'h0, 32'hC0DE_0000);
    pushExp(32'h4, 32'hC0DE_0001);
    pushExp(32'h8, 32'hC0DE_0002);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    waitCycles(3);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("bp_drain", 32'(expQ.size()), 32'd0);

    // Redirect from a full queue to 0x100
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
    waitCycles(1);
    checkOutput("redir_valid", {31'd0, inst_valid_o}, 32'd0);
    checkOutput("redir_addr", {19'd0, imem_addr_o}, 32'h100);
    checkOutput("redir_misalign", {31'd0, misalign_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    waitCycles(1);
    pushExp(32'h100, 32'hC0DE_0040);
    acceptOne();
    checkOutput("redir_drain", 32'(expQ.size()), 32'd0);

    // Misaligned redirect target 0x102
    applyStimulus(1'b1, 1'b1, 32'h102, 1'b0);
    waitCycles(1);
    checkOutput("mis_pulse", {31'd0, misalign_o}, 32'd1);
    checkOutput("mis_valid", {31'd0, inst_valid_o}, 32'd0);
    checkOutput("mis_addr", {19'd0, imem_addr_o}, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    waitCycles(1);
    checkOutput("mis_clear", {31'd0, misalign_o}, 32'd0);
    pushExp(32'h100, 32'hC0DE_0040);
    acceptOne();
    checkOutput("mis_drain", 32'(expQ.size()), 32'd0);

    // PC wrap from 0xFFFF_FFFC to 0
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    waitCycles(2);
    pushExp(32'hFFFF_FFFC, 32'hC0DE_07FF);
    pushExp(32'h0, 32'hC0DE_0000);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    waitCycles(2);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_drain", 32'(expQ.size()), 32'd0);

`ifdef IF_PERF_CNT_EN
    // Ten handshakes, then a redirect discarding two queued entries
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    waitCycles(1);
    checkOutput("perf_rst_fetch", fetch_cnt_o, 32'd0);
    checkOutput("perf_rst_flush", flush_cnt_o, 32'd0);
    for (int i = 0; i < 10; i++) begin
      pushExp(32'(4 * i), 32'hC0DE_0000 | 32'(i));
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    waitCycles(11);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("perf_fetch", fetch_cnt_o, 32'd10);
    checkOutput("perf_flush", flush_cnt_o, 32'd2);
    checkOutput("perf_drain", 32'(expQ.size()), 32'd0);
`endif

    waitCycles(2);
    checkOutput("final_drain", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
